interlaken_descrambler: RTL and testbench

INTERLAKEN_DESCRAMBLER -- requirements
Module: interlaken_descrambler

---
 rtl/interlaken_pkg.sv | 17 +
 rtl/interlaken_descrambler_lfsr58_adv64.sv | 27 ++
 rtl/interlaken_descrambler.sv | 134 +++++++++++++
 tb/tb_interlaken_descrambler.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/interlaken_pkg.sv
// Shared constants and lock-state type for the Interlaken descrambler.
// The LFSR is 58 bits wide, uses x^58 + x^39 + 1 and advances 64 steps per word.
package interlaken_pkg;

    localparam int LFSR_W   = 58;
    localparam int LFSR_TAP = 38;

    localparam logic [63:0] SYNC_WORD  = 64'h78F678F678F678F6;
    localparam logic [5:0]  SCRAM_TYPE = 6'b001010;

    typedef enum logic [1:0] {
        HUNT   = 2'd0,
        VERIFY = 2'd1,
        LOCKED = 2'd2
    } lock_state_t;

endpackage

// File: rtl/interlaken_descrambler_lfsr58_adv64.sv
// Combinational 64-step advance of the 58-bit scrambler LFSR.
// Keystream bit i (step i) is XORed into data bit 63-i.
module lfsr58_adv64
    import interlaken_pkg::*;
(
    input  logic [LFSR_W-1:0] state,
    input  logic [63:0]       data,
    output logic [LFSR_W-1:0] next_state,
    output logic [63:0]       data_out
);

    logic [LFSR_W-1:0] s;
    logic              k;

    always_comb begin
        s        = state;
        k        = 1'b0;
        data_out = data;
        for (int i = 0; i < 64; i++) begin
            k              = s[LFSR_W-1] ^ s[LFSR_TAP];
            data_out[63-i] = data[63-i] ^ k;
            s              = {s[LFSR_W-2:0], k};
        end
        next_state = s;
    end

endmodule

// File: rtl/interlaken_descrambler.sv
// Interlaken additive descrambler with scrambler-state lock tracking.
// Data words are XORed with the LFSR keystream; sync and state words pass through.
module interlaken_descrambler
    import interlaken_pkg::*;
#(
    parameter int LOCK_MATCHES    = 2,
    parameter int LOSS_MISMATCHES = 3
)
(
    input  logic        clk,
    input  logic        arst_n,
    input  logic        word_locked,
    input  logic        din_valid,
    input  logic        din_ctrl,
    input  logic [63:0] din,
    output logic        dout_valid,
    output logic        dout_ctrl,
    output logic [63:0] dout,
    output logic        scram_locked,
    output logic        state_err
);

    localparam int MW = $clog2(LOCK_MATCHES + 1);
    localparam int LW = $clog2(LOSS_MISMATCHES + 1);
    localparam logic [MW-1:0] MATCH_MAX = MW'(LOCK_MATCHES);
    localparam logic [LW-1:0] LOSS_MAX  = LW'(LOSS_MISMATCHES);

    lock_state_t       state, state_next;
    logic [LFSR_W-1:0] lfsr, adv_in, adv_out;
    logic [63:0]       descrambled;
    logic [MW-1:0]     match_cnt, match_cnt_next;
    logic [LW-1:0]     miss_cnt, miss_cnt_next;
    logic              err_next;
    logic              is_sync, is_state_word, state_evt, state_match;

    assign is_sync       = din_ctrl && (din == SYNC_WORD);
    assign is_state_word = din_ctrl && (din[63:58] == SCRAM_TYPE);
    assign state_evt     = din_valid && word_locked && is_state_word;
    assign state_match   = (din[LFSR_W-1:0] == lfsr);

    // A state word always leaves the LFSR at carried+64: equal to lfsr+64 on a
    // match and the required reload on a mismatch, so one network serves both.
    assign adv_in = state_evt ? din[LFSR_W-1:0] : lfsr;

    lfsr58_adv64 u_adv (
        .state      (adv_in),
        .data       (din),
        .next_state (adv_out),
        .data_out   (descrambled)
    );

    always_comb begin
        state_next     = state;
        match_cnt_next = match_cnt;
        miss_cnt_next  = miss_cnt;
        err_next       = 1'b0;
        if (!word_locked) begin
            state_next     = HUNT;
            match_cnt_next = '0;
            miss_cnt_next  = '0;
        end else if (state_evt) begin
            case (state)
                HUNT: begin
                    state_next     = VERIFY;
                    match_cnt_next = '0;
                    miss_cnt_next  = '0;
                end
                VERIFY: begin
                    if (state_match) begin
                        match_cnt_next = (match_cnt >= MATCH_MAX) ? MATCH_MAX : match_cnt + MW'(1);
                        if (match_cnt_next >= MATCH_MAX) begin
                            state_next    = LOCKED;
                            miss_cnt_next = '0;
                        end
                    end else begin
                        err_next       = 1'b1;
                        match_cnt_next = '0;
                    end
                end
                LOCKED: begin
                    if (state_match) begin
                        miss_cnt_next = '0;
                    end else begin
                        err_next      = 1'b1;
                        miss_cnt_next = (miss_cnt >= LOSS_MAX) ? LOSS_MAX : miss_cnt + LW'(1);
                        if (miss_cnt_next >= LOSS_MAX) begin
                            state_next     = HUNT;
                            match_cnt_next = '0;
                            miss_cnt_next  = '0;
                        end
                    end
                end
                default: begin
                    state_next     = HUNT;
                    match_cnt_next = '0;
                    miss_cnt_next  = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            state     <= HUNT;
            lfsr      <= '1;
            match_cnt <= '0;
            miss_cnt  <= '0;
        end else begin
            state     <= state_next;
            match_cnt <= match_cnt_next;
            miss_cnt  <= miss_cnt_next;
            if (din_valid && (state != HUNT || state_evt)) begin
                lfsr <= adv_out;
            end
        end
    end

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            dout       <= '0;
            dout_ctrl  <= 1'b0;
            dout_valid <= 1'b0;
            state_err  <= 1'b0;
        end else begin
            dout       <= (is_sync || is_state_word) ? din : descrambled;
            dout_ctrl  <= din_ctrl;
            dout_valid <= din_valid;
            state_err  <= err_next;
        end
    end

    assign scram_locked = (state == LOCKED);

endmodule

// File: tb/tb_interlaken_descrambler.sv
// Directed self-checking bench for interlaken_descrambler: a reference keystream
// model feeds a scoreboard queue that is popped one cycle after each word.
module tb_interlaken_descrambler;

    localparam logic [63:0] SYNC = 64'h78F678F678F678F6;
    localparam logic [57:0] S1   = 58'h2AAAAAAAAAAAAAA;
    localparam logic [57:0] S2   = 58'h0F0F0F0F0F0F0F0;
    localparam logic [57:0] S3   = 58'h3C3C3C3C3C3C3C3;

    typedef enum int {S_HUNT, S_VERIFY, S_LOCKED} tb_st_t;

    typedef struct {
        logic [63:0] dout;
        logic        ctrl;
        logic        valid;
        logic        locked;
        logic        err;
    } exp_t;

    logic        clk = 1'b0;
    logic        arst_n;
    logic        word_locked;
    logic        din_valid;
    logic        din_ctrl;
    logic [63:0] din;
    logic        dout_valid;
    logic        dout_ctrl;
    logic [63:0] dout;
    logic        scram_locked;
    logic        state_err;

    exp_t        sb[$];
    int          n_assert = 0;
    int          n_fail   = 0;
    logic [57:0] ref_lfsr;
    bit          rx_hunt;

    always #5 clk = ~clk;

    interlaken_descrambler dut (
        .clk          (clk),
        .arst_n       (arst_n),
        .word_locked  (word_locked),
        .din_valid    (din_valid),
        .din_ctrl     (din_ctrl),
        .din          (din),
        .dout_valid   (dout_valid),
        .dout_ctrl    (dout_ctrl),
        .dout         (dout),
        .scram_locked (scram_locked),
        .state_err    (state_err)
    );

    function automatic logic [57:0] advance(input logic [57:0] s);
        logic [57:0] r;
        logic        fb;
        r = s;
        for (int i = 0; i < 64; i++) begin
            fb = r[57] ^ r[38];
            r  = {r[56:0], fb};
        end
        return r;
    endfunction

    function automatic logic [63:0] keystream(input logic [57:0] s);
        logic [57:0] r;
        logic [63:0] ks;
        r  = s;
        ks = '0;
        for (int i = 0; i < 64; i++) begin
            ks[63-i] = r[57] ^ r[38];
            r        = {r[56:0], ks[63-i]};
        end
        return ks;
    endfunction

    function automatic logic [63:0] sw(input logic [57:0] s);
        return {6'b001010, s};
    endfunction

    function automatic logic [63:0] rnd64();
        return {$urandom(), $urandom()};
    endfunction

    task automatic check_field(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        n_assert++;
        assert (obs === expv) else begin
            n_fail++;
            $error("[TB] FAIL %s: observed %h expected %h", tag, obs, expv);
        end
    endtask

    task automatic check_reset(input string tag);
        check_field({tag, "_dout"},   dout, 64'h0);
        check_field({tag, "_ctrl"},   64'(dout_ctrl), 64'h0);
        check_field({tag, "_valid"},  64'(dout_valid), 64'h0);
        check_field({tag, "_locked"}, 64'(scram_locked), 64'h0);
        check_field({tag, "_err"},    64'(state_err), 64'h0);
    endtask

    task automatic check_output();
        exp_t e;
        if (sb.size() == 0) begin
            n_assert++;
            n_fail++;
            $error("[TB] FAIL scoreboard_empty: observed 0 entries expected 1");
            return;
        end
        e = sb.pop_front();
        check_field("valid",  64'(dout_valid), 64'(e.valid));
        check_field("locked", 64'(scram_locked), 64'(e.locked));
        check_field("err",    64'(state_err), 64'(e.err));
        if (e.valid) begin
            check_field("dout", dout, e.dout);
            check_field("ctrl", 64'(dout_ctrl), 64'(e.ctrl));
        end
    endtask

    // Drives one word, predicts the registered output and the receiver keystream state.
    task automatic apply_stimulus(input logic v, input logic c, input logic [63:0] d,
                                  input logic wl, input tb_st_t st_after, input logic err);
        exp_t e;
        logic is_sw;
        logic pass;
        @(negedge clk);
        din_valid   = v;
        din_ctrl    = c;
        din         = d;
        word_locked = wl;
        is_sw       = c && (d[63:58] == 6'b001010);
        pass        = is_sw || (c && (d == SYNC));
        e.dout      = pass ? d : (d ^ keystream(ref_lfsr));
        e.ctrl      = c;
        e.valid     = v;
        e.locked    = (st_after == S_LOCKED);
        e.err       = err;
        sb.push_back(e);
        if (v) begin
            if (is_sw && wl) ref_lfsr = advance(d[57:0]);
            else if (!rx_hunt) ref_lfsr = advance(ref_lfsr);
        end
        rx_hunt = (st_after == S_HUNT);
        @(posedge clk);
        #1;
        check_output();
    endtask

    initial begin
        arst_n      = 1'b0;
        word_locked = 1'b1;
        din_valid   = 1'b0;
        din_ctrl    = 1'b0;
        din         = '0;
        ref_lfsr    = '1;
        rx_hunt     = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check_reset("reset");
        @(posedge clk);
        #2 arst_n = 1'b1;

        $display("[TB] HUNT keystream from held all-ones LFSR");
        apply_stimulus(1, 0, 64'h0123456789ABCDEF, 1, S_HUNT, 0);
        apply_stimulus(1, 0, 64'hFEDCBA9876543210, 1, S_HUNT, 0);

        $display("[TB] acquire lock");
        apply_stimulus(1, 1, sw(S1), 1, S_VERIFY, 0);
        apply_stimulus(1, 1, sw(ref_lfsr), 1, S_VERIFY, 0);
        apply_stimulus(1, 1, sw(ref_lfsr), 1, S_LOCKED, 0);

        $display("[TB] locked data, sync and idle");
        apply_stimulus(1, 0, 64'h0, 1, S_LOCKED, 0);
        for (int i = 0; i < 4; i++) apply_stimulus(1, 0, rnd64(), 1, S_LOCKED, 0);
        apply_stimulus(1, 1, SYNC, 1, S_LOCKED, 0);
        apply_stimulus(1, 0, rnd64(), 1, S_LOCKED, 0);
        apply_stimulus(0, 0, rnd64(), 1, S_LOCKED, 0);
        apply_stimulus(1, 0, rnd64(), 1, S_LOCKED, 0);
        apply_stimulus(1, 1, 64'h1E00000000001234, 1, S_LOCKED, 0);

        $display("[TB] isolated mismatches keep lock");
        apply_stimulus(1, 1, sw(ref_lfsr ^ 58'h1), 1, S_LOCKED, 1);
        apply_stimulus(1, 1, sw(ref_lfsr), 1, S_LOCKED, 0);
        apply_stimulus(1, 1, sw(ref_lfsr ^ 58'h2), 1, S_LOCKED, 1);
        apply_stimulus(1, 1, sw(ref_lfsr ^ 58'h4), 1, S_LOCKED, 1);
        apply_stimulus(1, 1, sw(ref_lfsr), 1, S_LOCKED, 0);
        apply_stimulus(1, 0, rnd64(), 1, S_LOCKED, 0);

        $display("[TB] three mismatches drop lock");
        apply_stimulus(1, 1, sw(ref_lfsr ^ 58'h8), 1, S_LOCKED, 1);
        apply_stimulus(1, 1, sw(ref_lfsr ^ 58'h10), 1, S_LOCKED, 1);
        apply_stimulus(1, 1, sw(ref_lfsr ^ 58'h20), 1, S_HUNT, 1);
        apply_stimulus(1, 0, rnd64(), 1, S_HUNT, 0);

        $display("[TB] VERIFY mismatch restarts match count");
        apply_stimulus(1, 1, sw(S2), 1, S_VERIFY, 0);
        apply_stimulus(1, 1, sw(ref_lfsr), 1, S_VERIFY, 0);
        apply_stimulus(1, 1, sw(ref_lfsr ^ 58'h100), 1, S_VERIFY, 1);
        apply_stimulus(1, 1, sw(ref_lfsr), 1, S_VERIFY, 0);
        apply_stimulus(1, 1, sw(ref_lfsr), 1, S_LOCKED, 0);

        $display("[TB] word_locked low overrides state words");
        apply_stimulus(1, 1, sw(ref_lfsr), 0, S_HUNT, 0);
        apply_stimulus(1, 1, sw(S3), 0, S_HUNT, 0);
        apply_stimulus(1, 0, rnd64(), 1, S_HUNT, 0);

        $display("[TB] relock then reset mid-word");
        apply_stimulus(1, 1, sw(S3), 1, S_VERIFY, 0);
        apply_stimulus(1, 1, sw(ref_lfsr), 1, S_VERIFY, 0);
        apply_stimulus(1, 1, sw(ref_lfsr), 1, S_LOCKED, 0);
        apply_stimulus(1, 0, rnd64(), 1, S_LOCKED, 0);
        @(negedge clk);
        din_valid = 1'b1;
        din_ctrl  = 1'b0;
        din       = rnd64();
        #2 arst_n = 1'b0;
        #1;
        check_reset("async_reset");
        sb.delete();
        ref_lfsr = '1;
        rx_hunt  = 1'b1;
        @(posedge clk);
        #2 arst_n = 1'b1;
        apply_stimulus(1, 0, 64'hA5A5A5A55A5A5A5A, 1, S_HUNT, 0);
        apply_stimulus(1, 1, sw(S1), 1, S_VERIFY, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
